// File: rtl/pixel_cfg_pkg.sv
// Shared types and helpers for the pixel configuration loader.
// Holds the loader FSM states, the default word width and clog2.
package pixel_cfg_pkg;

  localparam int WORD_W_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } cfg_state_e;

  // Ceiling log2, never below 1 so it can size any vector.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cfg_word_fifo.sv
// Small synchronous word FIFO with flush and a sticky overflow flag.
// A push into a full FIFO is accepted when a pop frees a slot.
module cfg_word_fifo
  import pixel_cfg_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              ovf_clr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              empty,
  output logic              ovf
);

  localparam int AW = clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic              ovf_q, ovf_d;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];
  assign ovf   = ovf_q;

  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q & ~ovf_clr;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop) rd_d = rd_q + 1'b1;
      if (push && !do_push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pixel_cfg_loader.sv
// Buffers pixel config words and shifts them MSB-first into the
// pixel chain on a divided clock, then pulses the chain latch.
module pixel_cfg_loader
  import pixel_cfg_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int NUM_PIX    = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int HALF_DIV   = 2,
  parameter int LATCH_CYC  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          config_en,
  input  logic                          cfg_push,
  input  logic [WORD_W-1:0]             cfig_data,
  output logic                          cfg_sdo,
  output logic                          cfg_sclk,
  output logic                          cfg_latch,
  output logic                          config_do,
  output logic                          cfg_busy,
  output logic                          cfg_ovf,
  output logic [clog2(NUM_PIX+1)-1:0]   word_cnt
);

  localparam int CW   = clog2(NUM_PIX + 1);
  localparam int BW   = clog2(WORD_W);
  localparam int DMAX = (HALF_DIV > LATCH_CYC) ? HALF_DIV : LATCH_CYC;
  localparam int DW   = clog2(DMAX + 1);

  cfg_state_e        state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              sdo_q, sdo_d;
  logic              sclk_q, sclk_d;
  logic              latch_q, latch_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              en_q;

  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_dout;

  cfg_word_fifo #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cfg_push & config_en),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .ovf_clr (config_en & ~en_q),
    .din     (cfig_data),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .ovf     (cfg_ovf)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    wcnt_d     = wcnt_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        wcnt_d = '0;
        div_d  = '0;
        if (config_en) state_d = FETCH;
      end
      FETCH: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dout;
          bit_d    = BW'(WORD_W - 1);
          div_d    = '0;
          state_d  = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_q == DW'(HALF_DIV - 1)) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_q == DW'(HALF_DIV - 1)) begin
          div_d = '0;
          if (bit_q != '0) begin
            bit_d   = bit_q - 1'b1;
            sh_d    = sh_q << 1;
            state_d = SHIFT_LO;
          end else begin
            wcnt_d  = wcnt_q + 1'b1;
            state_d = (wcnt_q + 1'b1 == CW'(NUM_PIX)) ? LATCH : FETCH;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_q == DW'(LATCH_CYC - 1)) begin
          div_d   = '0;
          state_d = DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Dropping config_en ends the session: abort or DONE exit.
    if (!config_en && state_q != IDLE) begin
      state_d    = IDLE;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b1;
      wcnt_d     = '0;
      div_d      = '0;
    end
  end

  always_comb begin
    sclk_d  = (state_d == SHIFT_HI);
    sdo_d   = (state_d == SHIFT_LO || state_d == SHIFT_HI) ?
              sh_d[WORD_W-1] : 1'b0;
    latch_d = (state_d == LATCH);
    done_d  = (state_d == DONE);
    busy_d  = !(state_d == IDLE || state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      wcnt_q  <= '0;
      sdo_q   <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      wcnt_q  <= wcnt_d;
      sdo_q   <= sdo_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      en_q    <= config_en;
    end
  end

  assign cfg_sdo   = sdo_q;
  assign cfg_sclk  = sclk_q;
  assign cfg_latch = latch_q;
  assign config_do = done_q;
  assign cfg_busy  = busy_q;
  assign word_cnt  = wcnt_q;

endmodule

// File: tb/tb_pixel_cfg_loader.sv
// Directed bench: two loaders (2 and 5 words per frame) share stimulus;
// serial streams are captured at cfg_sclk rising edges.
module tb_pixel_cfg_loader;

  logic       clk;
  logic       rst;
  logic       en;
  logic       push;
  logic [5:0] data;

  logic       sdo_a, sclk_a, latch_a, do_a, busy_a, ovf_a;
  logic [1:0] wc_a;
  logic       sdo_b, sclk_b, latch_b, do_b, busy_b, ovf_b;
  logic [2:0] wc_b;

  pixel_cfg_loader #(
    .WORD_W(6), .NUM_PIX(2), .FIFO_DEPTH(4),
    .HALF_DIV(2), .LATCH_CYC(2)
  ) dut_a (
    .clk(clk), .rst(rst), .config_en(en),
    .cfg_push(push), .cfig_data(data),
    .cfg_sdo(sdo_a), .cfg_sclk(sclk_a),
    .cfg_latch(latch_a), .config_do(do_a),
    .cfg_busy(busy_a), .cfg_ovf(ovf_a),
    .word_cnt(wc_a)
  );

  pixel_cfg_loader #(
    .WORD_W(6), .NUM_PIX(5), .FIFO_DEPTH(4),
    .HALF_DIV(2), .LATCH_CYC(2)
  ) dut_b (
    .clk(clk), .rst(rst), .config_en(en),
    .cfg_push(push), .cfig_data(data),
    .cfg_sdo(sdo_b), .cfg_sclk(sclk_b),
    .cfg_latch(latch_b), .config_do(do_b),
    .cfg_busy(busy_b), .cfg_ovf(ovf_b),
    .word_cnt(wc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int edges_a, latch_n_a, run_a, hi_bad_a;
  int done_n_a, latch_at_done_a, edges_at_done_a;
  int wc_at_latch_a;
  logic [63:0] bits_a;
  logic sclk_pa, done_pa, latch_pa;

  int edges_b;
  logic [63:0] bits_b;
  logic sclk_pb;

  always @(negedge clk) begin
    if (sclk_a && !sclk_pa) begin
      edges_a++;
      bits_a = {bits_a[62:0], sdo_a};
    end
    if (sclk_a) run_a++;
    else begin
      if (run_a != 0 && run_a != 2) hi_bad_a++;
      run_a = 0;
    end
    if (latch_a) begin
      if (!latch_pa) wc_at_latch_a = int'(wc_a);
      latch_n_a++;
    end
    if (do_a && !done_pa) begin
      done_n_a++;
      latch_at_done_a = latch_n_a;
      edges_at_done_a = edges_a;
    end
    sclk_pa  = sclk_a;
    done_pa  = do_a;
    latch_pa = latch_a;
    if (sclk_b && !sclk_pb) begin
      edges_b++;
      bits_b = {bits_b[62:0], sdo_b};
    end
    sclk_pb = sclk_b;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic reset_mon();
    edges_a = 0; latch_n_a = 0; run_a = 0; hi_bad_a = 0;
    done_n_a = 0; latch_at_done_a = -1; edges_at_done_a = -1;
    wc_at_latch_a = -1; bits_a = '0;
    edges_b = 0; bits_b = '0;
  endtask

  task automatic start_frame(input logic [5:0] w0,
                             input logic [5:0] w1);
    en = 1'b1; push = 1'b1; data = w0;
    cyc();
    data = w1;
    cyc();
    push = 1'b0;
  endtask

  task automatic wait_done_a(input string nm);
    int n;
    n = 0;
    while (!do_a && n < 400) begin cyc(); n++; end
    chk(nm, 64'(do_a), 64'd1);
  endtask

  task automatic idle_en(input int n);
    en = 1'b0; push = 1'b0;
    repeat (n) cyc();
  endtask

  typedef struct {
    logic [5:0]  w0;
    logic [5:0]  w1;
    logic [11:0] exp;
  } vec_t;

  vec_t vt[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{6'b101101, 6'b010011, 12'b101101_010011};
    vt[1] = '{6'b000000, 6'b111111, 12'b000000_111111};
    vt[2] = '{6'b100000, 6'b000001, 12'b100000_000001};
    vt[3] = '{6'b111111, 6'b010101, 12'b111111_010101};

    sclk_pa = 0; done_pa = 0; latch_pa = 0; sclk_pb = 0;
    reset_mon();
    rst = 1'b1; en = 1'b0; push = 1'b0; data = '0;
    repeat (3) cyc();
    chk("reset outs a",
        64'({sdo_a, sclk_a, latch_a, do_a, busy_a, ovf_a, wc_a}), 64'd0);
    chk("reset outs b",
        64'({sdo_b, sclk_b, latch_b, do_b, busy_b, ovf_b, wc_b}), 64'd0);
    rst = 1'b0;
    cyc();

    // Table-driven single frames on the 2-word loader.
    for (int i = 0; i < 4; i++) begin
      idle_en(2);
      reset_mon();
      start_frame(vt[i].w0, vt[i].w1);
      wait_done_a($sformatf("frame%0d done", i));
      chk($sformatf("frame%0d bits", i), bits_a[11:0], vt[i].exp);
      chk($sformatf("frame%0d edges", i), edges_at_done_a, 12);
      chk($sformatf("frame%0d latch w", i), latch_at_done_a, 2);
      chk($sformatf("frame%0d sclk hi", i), hi_bad_a, 0);
      chk($sformatf("frame%0d wcnt", i), wc_at_latch_a, 2);
      chk($sformatf("frame%0d busy", i), busy_a, 0);
      en = 1'b0;
      cyc();
      chk($sformatf("frame%0d do fall", i), do_a, 0);
    end

    // Overflow on the 5-word loader.
    idle_en(3);
    reset_mon();
    en = 1'b1; push = 1'b1; data = 6'b110001;
    cyc();
    chk("ovf fetch sdo", sdo_b, 0);
    chk("ovf fetch busy", busy_b, 1);
    data = 6'b011010;
    cyc();
    chk("ovf first pop sdo", sdo_b, 1);
    data = 6'b101011; cyc();
    data = 6'b000111; cyc();
    data = 6'b111000; cyc();
    chk("ovf not yet", ovf_b, 0);
    data = 6'b010101; cyc();
    push = 1'b0;
    chk("ovf set", ovf_b, 1);
    begin
      int n;
      n = 0;
      while (!do_b && n < 1000) begin cyc(); n++; end
      chk("ovf done", do_b, 1);
    end
    chk("ovf edges", edges_b, 30);
    chk("ovf bits", bits_b[29:0],
        30'b110001_011010_101011_000111_111000);
    chk("ovf wcnt", wc_b, 5);
    en = 1'b0;
    cyc();
    chk("ovf sticky", ovf_b, 1);
    chk("ovf do fall", do_b, 0);
    en = 1'b1;
    cyc();
    chk("ovf clear on rise", ovf_b, 0);

    // Abort after 3 bits of word 0.
    idle_en(2);
    reset_mon();
    start_frame(6'b110110, 6'b001011);
    begin
      int n;
      n = 0;
      while (edges_a < 3 && n < 200) begin cyc(); n++; end
      chk("abort reach 3 bits", edges_a, 3);
    end
    en = 1'b0;
    cyc();
    chk("abort outs",
        64'({sdo_a, sclk_a, latch_a, do_a, busy_a, wc_a}), 64'd0);
    repeat (10) cyc();
    chk("abort no edges", edges_a, 3);
    chk("abort no latch", latch_n_a, 0);
    chk("abort no done", done_n_a, 0);
    reset_mon();
    start_frame(6'b100111, 6'b011100);
    wait_done_a("abort next done");
    chk("abort next bits", bits_a[11:0], 12'b100111_011100);
    chk("abort next edges", edges_at_done_a, 12);

    // Underrun: second word arrives 40 cycles later.
    idle_en(2);
    reset_mon();
    en = 1'b1; push = 1'b1; data = 6'b011001;
    cyc();
    push = 1'b0;
    repeat (39) cyc();
    chk("underrun edges", edges_a, 6);
    chk("underrun sclk", sclk_a, 0);
    chk("underrun busy", busy_a, 1);
    push = 1'b1; data = 6'b110100;
    cyc();
    push = 1'b0;
    wait_done_a("underrun done");
    chk("underrun bits", bits_a[11:0], 12'b011001_110100);
    chk("underrun edges tot", edges_at_done_a, 12);
    chk("underrun wcnt", wc_at_latch_a, 2);
    chk("underrun sclk hi", hi_bad_a, 0);

    // Push while config_en is low.
    idle_en(2);
    reset_mon();
    push = 1'b1; data = 6'b111111;
    cyc();
    push = 1'b0;
    cyc();
    chk("en0 push ovf", ovf_a, 0);
    chk("en0 push busy", busy_a, 0);
    en = 1'b1;
    repeat (10) cyc();
    chk("en0 push not stored", edges_a, 0);

    // Synchronous reset mid-shift while cfg_sclk is high.
    idle_en(2);
    reset_mon();
    start_frame(6'b101010, 6'b110011);
    begin
      int n;
      n = 0;
      while (!sclk_a && n < 100) begin cyc(); n++; end
      chk("rst reach shift_hi", sclk_a, 1);
    end
    rst = 1'b1;
    cyc();
    chk("rst mid outs",
        64'({sdo_a, sclk_a, latch_a, do_a, busy_a, ovf_a, wc_a}), 64'd0);
    rst = 1'b0;
    reset_mon();
    repeat (10) cyc();
    chk("rst fifo empty", edges_a, 0);
    chk("rst sdo", sdo_a, 0);
    idle_en(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
